// File: rtl/scan_reg_pkg.sv
// Shared types and constant helpers for the scan register bank.
// The optional output mask is controlled by the SCAN_MASK_EN macro in scan_reg_bank.
package scan_reg_pkg;

  // Per-edge operating mode decoded from SE/EN. SE wins over EN.
  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_FUNC  = 2'd1,
    MODE_SHIFT = 2'd2
  } mode_e;

  // Total number of flops in the serial scan chain.
  function automatic int chain_len(input int width, input int stages);
    return width * stages;
  endfunction

  // Smallest r with 2**r >= value. Used to check the counter width.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // SE selects shifting regardless of EN; otherwise EN advances the pipe.
  function automatic mode_e decode_mode(input logic se, input logic en);
    mode_e m;
    if (se)      m = MODE_SHIFT;
    else if (en) m = MODE_FUNC;
    else         m = MODE_HOLD;
    return m;
  endfunction

endpackage

// File: rtl/scan_reg_stage.sv
// One WIDTH-bit pipeline stage. In shift mode the bits form a serial chain
// SI -> Q[0] -> Q[1] -> ... -> Q[WIDTH-1] = SO.
module scan_reg_stage
  import scan_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO
);

  logic [WIDTH-1:0] stage_d;
  logic [WIDTH-1:0] stage_q;
  mode_e            mode;

  // Next-state select: hold, parallel load from D, or shift one bit along.
  always_comb begin
    mode    = decode_mode(SE, EN);
    stage_d = stage_q;
    case (mode)
      MODE_HOLD: stage_d = stage_q;
      MODE_FUNC: stage_d = D;
      MODE_SHIFT: begin
        stage_d[0] = SI;
        for (int i = 1; i < WIDTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end
      default: stage_d = stage_q;
    endcase
  end

  // Stage register with synchronous reset.
  always_ff @(posedge CK) begin
    if (RST) stage_q <= '0;
    else     stage_q <= stage_d;
  end

  assign Q  = stage_q;
  assign SO = stage_q[WIDTH-1];

endmodule

// File: rtl/scan_reg_bank.sv
// WIDTH x STAGES scan-accessible register pipeline with a shift counter that
// pulses SHIFT_DONE after each full-chain load/unload.
// Optional: define SCAN_MASK_EN to force Q to zero the cycle after SE rises
// until the cycle after SE falls (registered SE gates Q).
module scan_reg_bank
  import scan_reg_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             SE,
  input  logic [WIDTH-1:0] D,
  input  logic             SI,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CNT_W-1:0] SHIFT_CNT,
  output logic             SHIFT_DONE
);

  localparam int               CHAIN_LEN = chain_len(WIDTH, STAGES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CHAIN_LEN - 1);

  if (CNT_W < clog2(CHAIN_LEN)) begin : g_bad_cnt_w
    $error("scan_reg_bank: CNT_W too small for chain length");
  end

  logic [STAGES-1:0][WIDTH-1:0] stage_out;
  logic [STAGES-1:0]            stage_so;

  // Stage s takes the previous stage's word as functional input and its SO as
  // serial input, so the chain runs stage 0 LSB first through to the last MSB.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0] in_d;
    logic             in_si;
    if (s == 0) begin : g_head
      assign in_d  = D;
      assign in_si = SI;
    end else begin : g_link
      assign in_d  = stage_out[s-1];
      assign in_si = stage_so[s-1];
    end
    scan_reg_stage #(.WIDTH(WIDTH)) u_stage (
      .CK (CK),
      .RST(RST),
      .EN (EN),
      .SE (SE),
      .D  (in_d),
      .SI (in_si),
      .Q  (stage_out[s]),
      .SO (stage_so[s])
    );
  end

  logic [CNT_W-1:0] shift_cnt_d, shift_cnt_q;
  logic             shift_done_d, shift_done_q;

  // Count shifts in the current burst; wrap and pulse on the last chain position.
  always_comb begin
    shift_cnt_d  = '0;
    shift_done_d = 1'b0;
    if (SE) begin
      if (shift_cnt_q == CNT_LAST) begin
        shift_cnt_d  = '0;
        shift_done_d = 1'b1;
      end else begin
        shift_cnt_d = shift_cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter and done-pulse registers; reset abandons any burst in progress.
  always_ff @(posedge CK) begin
    if (RST) begin
      shift_cnt_q  <= '0;
      shift_done_q <= 1'b0;
    end else begin
      shift_cnt_q  <= shift_cnt_d;
      shift_done_q <= shift_done_d;
    end
  end

  assign SHIFT_CNT  = shift_cnt_q;
  assign SHIFT_DONE = shift_done_q;
  assign SO         = stage_so[STAGES-1];

`ifdef SCAN_MASK_EN
  logic se_d, se_q;

  // Registered copy of SE so the mask is driven purely from flops.
  always_comb se_d = SE;

  // SE history register used only for output masking.
  always_ff @(posedge CK) begin
    if (RST) se_q <= 1'b0;
    else     se_q <= se_d;
  end

  assign Q = se_q ? '0 : stage_out[STAGES-1];
`else
  assign Q = stage_out[STAGES-1];
`endif

endmodule

// File: tb/tb_scan_reg_bank.sv
// Directed bench for scan_reg_bank (WIDTH=4, STAGES=2, chain of 8).
// Driver pushes the expected post-edge outputs; a monitor pops and compares.
module tb_scan_reg_bank;

  localparam int WIDTH  = 4;
  localparam int STAGES = 2;
  localparam int CNT_W  = 8;
`ifdef SCAN_MASK_EN
  localparam bit MASK_BUILD = 1'b1;
`else
  localparam bit MASK_BUILD = 1'b0;
`endif
  localparam logic [3:0] ALL = 4'hF;

  logic             CK;
  logic             RST;
  logic             EN;
  logic             SE;
  logic [WIDTH-1:0] D;
  logic             SI;
  logic [WIDTH-1:0] Q;
  logic             SO;
  logic [CNT_W-1:0] SHIFT_CNT;
  logic             SHIFT_DONE;

  scan_reg_bank #(.WIDTH(WIDTH), .STAGES(STAGES), .CNT_W(CNT_W)) dut (
    .CK        (CK),
    .RST       (RST),
    .EN        (EN),
    .SE        (SE),
    .D         (D),
    .SI        (SI),
    .Q         (Q),
    .SO        (SO),
    .SHIFT_CNT (SHIFT_CNT),
    .SHIFT_DONE(SHIFT_DONE)
  );

  // ---------------- clock / reset ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // Fields: id, enable mask {q,so,cnt,done}, expected q, so, cnt, done.
  typedef struct packed {
    logic [15:0]      id;
    logic [3:0]       m;
    logic [WIDTH-1:0] q;
    logic             so;
    logic [CNT_W-1:0] cnt;
    logic             done;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   vec_id      = 0;
  exp_t mon_e;
  logic mon_bad;

  // Monitor: each edge's outputs are checked against the oldest expectation.
  always @(posedge CK) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e   = exp_q.pop_front();
      mon_bad = 1'b0;
      if (mon_e.m[3] && (Q !== mon_e.q)) begin
        $display("FAIL vec%0d Q: got %h want %h", mon_e.id, Q, mon_e.q);
        mon_bad = 1'b1;
      end
      if (mon_e.m[2] && (SO !== mon_e.so)) begin
        $display("FAIL vec%0d SO: got %b want %b", mon_e.id, SO, mon_e.so);
        mon_bad = 1'b1;
      end
      if (mon_e.m[1] && (SHIFT_CNT !== mon_e.cnt)) begin
        $display("FAIL vec%0d SHIFT_CNT: got %0d want %0d", mon_e.id, SHIFT_CNT, mon_e.cnt);
        mon_bad = 1'b1;
      end
      if (mon_e.m[0] && (SHIFT_DONE !== mon_e.done)) begin
        $display("FAIL vec%0d SHIFT_DONE: got %b want %b", mon_e.id, SHIFT_DONE, mon_e.done);
        mon_bad = 1'b1;
      end
      vectors++;
      if (mon_bad) miscompares++;
    end
  end

  // ---------------- driver ----------------
  // Apply inputs for one edge and queue the outputs expected after that edge.
  task automatic cyc(input logic rst, input logic se, input logic en,
                     input logic [WIDTH-1:0] d, input logic si,
                     input logic [3:0] m, input logic [WIDTH-1:0] eq,
                     input logic eso, input logic [CNT_W-1:0] ecnt,
                     input logic edone);
    exp_t e;
    @(negedge CK);
    RST = rst;
    SE  = se;
    EN  = en;
    D   = d;
    SI  = si;
    e.id   = 16'(vec_id);
    e.m    = m;
    e.q    = (MASK_BUILD && se && !rst) ? '0 : eq;
    e.so   = eso;
    e.cnt  = ecnt;
    e.done = edone;
    exp_q.push_back(e);
    vec_id++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]       si_pat;
    logic [WIDTH-1:0] q_tab1 [8];
    logic [7:0]       so_tab1;
    logic [WIDTH-1:0] q_tab2 [8];
    logic [7:0]       so_tab2;
    logic [WIDTH-1:0] q_tab3 [5];
    logic [4:0]       so_tab3;
    logic [WIDTH-1:0] q_tab4 [8];
    logic [7:0]       so_tab4;

    // Chain contents before the first burst: stage1=0x5, stage0=0x3.
    si_pat  = 8'b1011_0010;  // applied MSB first
    q_tab1  = '{4'hA, 4'h4, 4'h9, 4'h3, 4'h7, 4'hE, 4'hD, 4'hB};
    so_tab1 = 8'b1010_0111;  // MSB = after first edge
    q_tab2  = '{4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};
    so_tab2 = 8'b0110_0100;
    q_tab3  = '{4'hE, 4'hC, 4'h8, 4'h0, 4'h1};
    so_tab3 = 5'b11100;
    q_tab4  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
    so_tab4 = 8'b0000_0001;

    RST = 1'b1; SE = 1'b0; EN = 1'b0; D = '0; SI = 1'b0;

    // Reset state
    cyc(1, 0, 0, 4'h0, 0, ALL, 4'h0, 0, 8'd0, 0);

    // Functional pipeline: D=A then 5 -> Q=A two edges after first D
    cyc(0, 0, 1, 4'hA, 0, ALL, 4'h0, 0, 8'd0, 0);
    cyc(0, 0, 1, 4'h5, 0, ALL, 4'hA, 1, 8'd0, 0);
    cyc(0, 0, 1, 4'h3, 0, ALL, 4'h5, 0, 8'd0, 0);

    // Hold with D changed to F
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 4'hF, 0, ALL, 4'h5, 0, 8'd0, 0);

    // First 8-shift burst; SO drains old contents, done only after 8th edge
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, 4'h0, si_pat[7-i], ALL, q_tab1[i], so_tab1[7-i],
          8'((i + 1) % 8), (i == 7));

    // Second burst with SI=0; SO replays the pattern, back-to-back done
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, 4'h0, 0, ALL, q_tab2[i], so_tab2[7-i],
          8'((i + 1) % 8), (i == 7));

    // Leave scan mode
    cyc(0, 0, 0, 4'h0, 0, ALL, 4'h0, 0, 8'd0, 0);

    // SE and EN together with D=F: shift wins
    for (int i = 0; i < 3; i++)
      cyc(0, 1, 1, 4'hF, 1, ALL, 4'h0, 0, 8'(i + 1), 0);
    // Drop SE mid-burst: counter clears, no pulse
    cyc(0, 0, 0, 4'hF, 0, ALL, 4'h0, 0, 8'd0, 0);
    // Advance once: stage0 held 0111 from shifting, not F from D
    cyc(0, 0, 1, 4'h0, 0, ALL, 4'h7, 0, 8'd0, 0);

    // Five shifts then reset mid-burst
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 0, 4'h0, 1, ALL, q_tab3[i], so_tab3[4-i], 8'(i + 1), 0);
    cyc(1, 1, 0, 4'h0, 1, ALL, 4'h0, 0, 8'd0, 0);

    // Fresh burst: done after 8 shifts, not 3
    for (int i = 0; i < 8; i++)
      cyc(0, 1, 0, 4'h0, 1, ALL, q_tab4[i], so_tab4[7-i],
          8'((i + 1) % 8), (i == 7));
    cyc(0, 0, 0, 4'h0, 0, ALL, 4'hF, 1, 8'd0, 0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge CK);
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      miscompares++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/scan_reg_bank.md
Name: scan_reg_bank

Overview:
- Parametrised successor to the single-bit scan flip-flop cell.
- A WIDTH-bit, STAGES-deep register pipeline for functional data. In scan mode, all WIDTH*STAGES flops form one serial chain.
- Adds hold (EN), synchronous reset, and a shift counter that flags completion of a full-chain load or unload.
- Used in the masked datapath wherever share registers must be scan-accessible.

Parameters:
- WIDTH, 8, bits per stage (>=1).
- STAGES, 2, pipeline depth (>=1).
- CNT_W, 8, width of shift counter; must satisfy 2**CNT_W >= WIDTH*STAGES.

Ports:
- CK  input  1  clock; all flops update on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  functional advance enable.
- SE  input  1  scan enable; selects serial shift.
- D  input  WIDTH  functional data into stage 0.
- SI  input  1  serial scan input.
- Q  output  WIDTH  contents of stage STAGES-1.
- SO  output  1  serial scan output (last flop of chain).
- SHIFT_CNT  output  CNT_W  number of shifts in the current scan burst, modulo CHAIN_LEN.
- SHIFT_DONE  output  1  one-cycle pulse after every CHAIN_LEN-th consecutive shift.

Behaviour:
- CHAIN_LEN = WIDTH*STAGES.
- Priority at each rising CK edge: RST > SE > EN > hold.
- Reset (RST=1):
  - All stage flops, SHIFT_CNT and SHIFT_DONE go to 0.
  - Q=0, SO=0 from the next cycle.
  - RST mid-burst abandons the burst; the counter restarts at 0.
- Functional mode (SE=0, EN=1):
  - stage[0] <= D; stage[i] <= stage[i-1].
  - Latency from D to Q is STAGES enabled edges.
- Hold (SE=0, EN=0): all stages keep their value.
- Any SE=0 cycle clears SHIFT_CNT to 0 and SHIFT_DONE to 0.
- Shift mode (SE=1):
  - EN is ignored.
  - Serial order: SI -> stage0[0] -> stage0[1] -> ... -> stage0[WIDTH-1] -> stage1[0] -> ... -> stage[STAGES-1][WIDTH-1] = SO.
  - Every flop takes its predecessor's value each edge.
  - SO is the registered last flop, not a combinational path from SI.
- Counter during SE=1:
  - SHIFT_CNT increments each edge.
  - When SHIFT_CNT == CHAIN_LEN-1, it wraps to 0 and SHIFT_DONE is set to 1 for exactly one cycle.
  - Otherwise SHIFT_DONE=0.
- Back-to-back bursts: with SE held high, SHIFT_DONE pulses every CHAIN_LEN cycles.
- SE toggling: the switch takes effect on the same edge. There is no dead cycle.
- Data is preserved across mode switches; only the flops are moved, never cleared, except by RST.
- Q and SO come directly from flops. No combinational path from inputs to outputs.

Optional Feature:
- Macro: SCAN_MASK_EN.
- When defined:
  - Q is forced to all-zero while SE=1. A registered copy of SE gates Q, so masking starts the cycle after SE rises and ends the cycle after SE falls.
  - This stops scan shifting from driving share-dependent toggles into downstream logic.
  - Internal flops and SO are unaffected.
- When undefined: Q always equals stage[STAGES-1], and the SE register is not instantiated.

Decomposition:
- Package scan_reg_pkg holds:
  - a chain_len(WIDTH, STAGES) constant function;
  - a clog2 helper used to check CNT_W;
  - a mode enum {MODE_HOLD, MODE_FUNC, MODE_SHIFT} decoded from SE/EN.
- Natural sub-module: scan_reg_stage, one WIDTH-bit stage.
  - Inputs: D, SI, SE, EN, RST, CK.
  - Outputs: Q and SO = Q[WIDTH-1].
  - scan_reg_bank instantiates STAGES of these, chaining each SO to the next SI, and adds the counter and the optional mask.

Test Plan (WIDTH=4, STAGES=2, CHAIN_LEN=8):
- Reset, then EN=1, SE=0, D=0xA then 0x5 on consecutive cycles -> Q=0xA two edges after the first D, Q=0x5 one edge later; SHIFT_CNT=0.
- Load 0xA/0x5 as above, hold EN=0 for 5 cycles -> Q stays 0x5; change D to 0xF -> Q unchanged.
- SE=1, SI pattern 1,0,1,1,0,0,1,0 over 8 cycles -> SHIFT_DONE=1 only in the cycle after the 8th edge; SHIFT_CNT 1..7 then 0. Shift 8 more with SI=0 -> SO emits the same pattern in input order.
- SE=1 and EN=1 simultaneously with D=0xF -> shift occurs and D is ignored; drop SE after 3 shifts -> SHIFT_CNT=0, no SHIFT_DONE pulse.
- RST=1 after 5 shifts -> next cycle all flops 0, Q=0, SO=0, SHIFT_CNT=0; a fresh 8-shift burst pulses SHIFT_DONE after 8, not 3.
- With SCAN_MASK_EN: stages hold 0x5, raise SE -> Q=0x5 on the first cycle, then 0x0 while SE stays high; drop SE -> Q shows the shifted contents one cycle later. Without the macro -> Q tracks the shifting contents every cycle.
